aes_lite_key_sched: RTL and testbench

Round-key scheduler sitting directly upstream of the 8-bit AES-lite encryption core. It captures an 8-bit cipher key and expands it into NUM_ROUNDS+1 round keys held in an internal register file. It then serves them to the core's round FSM through a one-cycle request/response port. Key expansion is decoupled from encryption, so the core reads round keys without recomputing them.

---
 rtl/aes_lite_key_sched.sv | 175 +++++++++++++++++
 tb/tb_aes_lite_key_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_lite_key_sched.sv
// Round-key scheduler for the 8-bit AES-lite core: expands one key into NUM_ROUNDS+1 round keys and serves them by index.
// Optional build macro AES_LITE_KS_SBOX_EN adds a 4-bit S-box on the low nibble of rk[1..NUM_ROUNDS].
module aes_lite_key_sched #(
  parameter int unsigned NUM_ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_in,
  input  logic       key_load,
  output logic       busy,
  output logic       keys_valid,
  input  logic       rk_req,
  input  logic [3:0] rk_idx,
  output logic [7:0] rk_out,
  output logic       rk_valid,
  output logic       rk_err
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] prev_q;
  logic       busy_q, kv_q, vld_q, err_q;
  logic [7:0] out_q;
  logic [7:0] rf_q [0:NUM_ROUNDS];

  logic [7:0] rk_next_d;
  logic [7:0] rd_key_d;
  logic       idx_bad_d;
  logic       rf_we_d;
  logic [3:0] rf_waddr_d;
  logic [7:0] rf_wdata_d;
  logic       start_d;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1B;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_LITE_KS_SBOX_EN
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;
      4'h1: return 4'h5;
      4'h2: return 4'h6;
      4'h3: return 4'hB;
      4'h4: return 4'h9;
      4'h5: return 4'h0;
      4'h6: return 4'hA;
      4'h7: return 4'hD;
      4'h8: return 4'h3;
      4'h9: return 4'hE;
      4'hA: return 4'hF;
      4'hB: return 4'h8;
      4'hC: return 4'h4;
      4'hD: return 4'h7;
      4'hE: return 4'h1;
      default: return 4'h2;
    endcase
  endfunction
`endif

  // prev_q mirrors the last entry written, so expansion never needs a register-file read port.
  always_comb begin
    logic [7:0] rx;
    rx = {prev_q[6:0], prev_q[7]} ^ rcon(cnt_q);
`ifdef AES_LITE_KS_SBOX_EN
    rk_next_d = {rx[7:4], sbox(rx[3:0])};
`else
    rk_next_d = rx;
`endif
  end

  assign start_d   = key_load && (state_q != EXPAND);
  assign idx_bad_d = rk_idx > LAST;

  always_comb begin
    rd_key_d = 8'h00;
    for (int i = 0; i <= int'(NUM_ROUNDS); i++)
      if (rk_idx == 4'(i)) rd_key_d = rf_q[i];
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = 4'd0;
    rf_wdata_d = key_in;
    if (rst_n) begin
      if (start_d) begin
        rf_we_d = 1'b1;
      end else if (state_q == EXPAND) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = rk_next_d;
      end
    end
  end

  // Register file carries no reset; contents only matter once a schedule is complete.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= int'(NUM_ROUNDS); i++)
      if (rf_we_d && rf_waddr_d == 4'(i)) rf_q[i] <= rf_wdata_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      prev_q  <= 8'h00;
      busy_q  <= 1'b0;
      kv_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= 8'h00;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_load) begin
            prev_q  <= key_in;
            cnt_q   <= 4'd1;
            busy_q  <= 1'b1;
            kv_q    <= 1'b0;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          prev_q <= rk_next_d;
          if (cnt_q == LAST) begin
            busy_q  <= 1'b0;
            kv_q    <= 1'b1;
            state_q <= READY;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        READY: begin
          if (key_load) begin
            prev_q  <= key_in;
            cnt_q   <= 4'd1;
            busy_q  <= 1'b1;
            kv_q    <= 1'b0;
            state_q <= EXPAND;
          end else if (rk_req) begin
            vld_q <= 1'b1;
            err_q <= idx_bad_d;
            out_q <= idx_bad_d ? 8'h00 : rd_key_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign keys_valid = kv_q;
  assign rk_out     = out_q;
  assign rk_valid   = vld_q;
  assign rk_err     = err_q;

endmodule

// File: tb/tb_aes_lite_key_sched.sv
// Randomized + directed bench for aes_lite_key_sched against a cycle-level behavioural schedule model.
module tb_aes_lite_key_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       key_load = 1'b0;
  logic       busy, keys_valid;
  logic       rk_req = 1'b0;
  logic [3:0] rk_idx = 4'd0;
  logic [7:0] rk_out;
  logic       rk_valid, rk_err;

  int checks = 0;
  int errors = 0;

  aes_lite_key_sched #(.NUM_ROUNDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .busy(busy), .keys_valid(keys_valid), .rk_req(rk_req), .rk_idx(rk_idx),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_err(rk_err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] sched_t [0:15];

  logic [7:0] rcon_t [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [3:0] sbox_t [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic sched_t expand(input logic [7:0] k);
    sched_t s;
    int v;
    for (int i = 0; i < 16; i++) s[i] = 8'h00;
    s[0] = k;
    for (int i = 1; i <= N; i++) begin
      v = ((int'(s[i-1]) * 2) % 256) + (int'(s[i-1]) / 128);
      v = v ^ int'(rcon_t[i]);
`ifdef AES_LITE_KS_SBOX_EN
      v = (v / 16) * 16 + int'(sbox_t[v % 16]);
`endif
      s[i] = 8'(v);
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs after each rising edge.
  sched_t     m_sched;
  int         m_rem = 0;
  bit         m_ready = 0;
  bit         m_en = 0;
  logic       e_busy = 0, e_kv = 0, e_vld = 0, e_err = 0;
  logic [7:0] e_out = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_ready = 0; m_en = 1;
      e_busy = 0; e_kv = 0; e_vld = 0; e_err = 0; e_out = 8'h00;
    end else begin
      e_vld = 0; e_err = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin e_busy = 0; e_kv = 1; m_ready = 1; end
      end else if (key_load) begin
        m_sched = expand(key_in);
        m_rem = N; e_busy = 1; e_kv = 0; m_ready = 0;
      end else if (m_ready && rk_req) begin
        e_vld = 1;
        if (int'(rk_idx) > N) begin e_err = 1; e_out = 8'h00; end
        else e_out = m_sched[rk_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("cyc_busy", 32'(busy), 32'(e_busy));
      chk("cyc_keys_valid", 32'(keys_valid), 32'(e_kv));
      chk("cyc_rk_valid", 32'(rk_valid), 32'(e_vld));
      chk("cyc_rk_err", 32'(rk_err), 32'(e_err));
      chk("cyc_rk_out", 32'(rk_out), 32'(e_out));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] k);
    key_load = 1'b1; key_in = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!keys_valid && cyc < 50) begin tick(); cyc++; end
    if (!keys_valid) chk("wait_ready_timeout", 32'(keys_valid), 32'd1);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] exp, input string nm);
    rk_req = 1'b1; rk_idx = idx;
    tick();
    rk_req = 1'b0;
    chk({nm, "_valid"}, 32'(rk_valid), 32'd1);
    chk({nm, "_data"}, 32'(rk_out), 32'(exp));
  endtask

  initial begin
    int cyc;
    sched_t s;
    logic [7:0] exp55 [0:4] = '{8'h55, 8'hAB, 8'h55, 8'hAE, 8'h55};
    logic [7:0] expFF [0:4] = '{8'hFF, 8'hFE, 8'hFF, 8'hFB, 8'hFF};
    logic [7:0] exp00 [0:4] = '{8'h00, 8'h01, 8'h00, 8'h04, 8'h00};

    // Pin the model to hand-derived values.
`ifdef AES_LITE_KS_SBOX_EN
    s = expand(8'h00);
    chk("model_sbox_k00_1", 32'(s[1]), 32'h05);
    s = expand(8'h55);
    chk("model_sbox_k55_0", 32'(s[0]), 32'h55);
`else
    s = expand(8'h55);
    for (int i = 0; i <= N; i++) chk("model_k55", 32'(s[i]), 32'(exp55[i]));
    s = expand(8'hFF);
    chk("model_kFF_3", 32'(s[3]), 32'hFB);
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kv", 32'(keys_valid), 32'd0);
    chk("rst_out", 32'(rk_out), 32'd0);

    // Read during IDLE is dropped.
    rk_req = 1'b1; rk_idx = 4'd0; tick(); rk_req = 1'b0;
    chk("idle_req_dropped", 32'(rk_valid), 32'd0);

    load(8'h55);
    chk("load_busy", 32'(busy), 32'd1);
    wait_ready(cyc);
    chk("expand_cycles", 32'(cyc), 32'(N));
    chk("ready_busy_low", 32'(busy), 32'd0);
`ifndef AES_LITE_KS_SBOX_EN
    for (int i = 0; i <= N; i++) rd(4'(i), exp55[i], "k55");
    load(8'hFF); wait_ready(cyc);
    for (int i = 0; i <= N; i++) rd(4'(i), expFF[i], "kFF");
    load(8'h00); wait_ready(cyc);
    for (int i = 0; i <= N; i++) rd(4'(i), exp00[i], "k00");
`else
    load(8'h00); wait_ready(cyc);
    rd(4'd1, 8'h05, "sbox_k00");
`endif
    tick();
    chk("strobe_clears", 32'(rk_valid), 32'd0);

    // Out-of-range index.
    rk_req = 1'b1; rk_idx = 4'd7; tick(); rk_req = 1'b0;
    chk("oob_valid", 32'(rk_valid), 32'd1);
    chk("oob_err", 32'(rk_err), 32'd1);
    chk("oob_out", 32'(rk_out), 32'd0);

    // Request during EXPAND dropped; second key_load ignored.
    load(8'h00);
    rk_req = 1'b1; rk_idx = 4'd1; key_load = 1'b1; key_in = 8'hFF; tick();
    rk_req = 1'b0; key_load = 1'b0;
    chk("expand_req_dropped", 32'(rk_valid), 32'd0);
    wait_ready(cyc);
    chk("expand_cycles_2", 32'(cyc), 32'(N - 1));
`ifdef AES_LITE_KS_SBOX_EN
    rd(4'd1, 8'h05, "ignored_reload");
`else
    rd(4'd1, 8'h01, "ignored_reload");
`endif

    // key_load wins over rk_req in READY.
    key_load = 1'b1; key_in = 8'hA5; rk_req = 1'b1; rk_idx = 4'd0; tick();
    key_load = 1'b0; rk_req = 1'b0;
    chk("collide_no_resp", 32'(rk_valid), 32'd0);
    chk("collide_busy", 32'(busy), 32'd1);
    chk("collide_kv_low", 32'(keys_valid), 32'd0);

    // Reset mid-expansion.
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_kv", 32'(keys_valid), 32'd0);
    chk("midrst_out", 32'(rk_out), 32'd0);
    repeat (N + 2) tick();
    chk("midrst_kv_stays", 32'(keys_valid), 32'd0);
    load(8'h3C); wait_ready(cyc);
    chk("midrst_reexpand", 32'(cyc), 32'(N));

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      key_load = ($urandom_range(0, 24) == 0);
      key_in   = 8'($urandom);
      rk_req   = ($urandom_range(0, 3) != 0);
      rk_idx   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, N));
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; key_load = 1'b0; rk_req = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
